// File: rtl/leaf_user_port.sv
// leaf_user_port
//   User-clock-side endpoint for one receive stream (interface2user) and one
//   transmit stream (user2interface) of a leaf interface. Each direction is a
//   FIFO_DEPTH-entry first-word-fall-through FIFO.
//
//   Handshake rule used on every stream of this block: a word moves on the
//   rising edge of clk_user where its valid and its ack/ready are both 1.
//   A valid, once raised, holds together with its data until accepted. Every
//   ack/ready is derived only from registered FIFO level, so no combinational
//   path exists from an incoming valid to the outgoing ack/ready.
//
//   Ports
//     clk_user, reset              clock, async active-high reset
//     dout_leaf_interface2user,    receive stream from the leaf interface
//     vld_interface2user,
//     ack_user2interface
//     rx_data, rx_valid, rx_ready  receive FIFO head toward the kernel
//     tx_data, tx_valid, tx_ready  kernel words into the transmit FIFO
//     din_leaf_user2interface,     transmit stream to the leaf interface
//     vld_user2interface,
//     ack_interface2user
//     rx_level, tx_level           FIFO occupancies
//     rx_words, tx_words           wrapping transferred-word counters
module leaf_user_port #(
  parameter int PAYLOAD_BITS = 32,
  parameter int FIFO_DEPTH   = 4,
  parameter int ADDR_BITS    = 2,
  parameter int CNT_BITS     = 16
) (
  input  logic                    clk_user,
  input  logic                    reset,
  input  logic [PAYLOAD_BITS-1:0] dout_leaf_interface2user,
  input  logic                    vld_interface2user,
  output logic                    ack_user2interface,
  output logic [PAYLOAD_BITS-1:0] rx_data,
  output logic                    rx_valid,
  input  logic                    rx_ready,
  input  logic [PAYLOAD_BITS-1:0] tx_data,
  input  logic                    tx_valid,
  output logic                    tx_ready,
  output logic [PAYLOAD_BITS-1:0] din_leaf_user2interface,
  output logic                    vld_user2interface,
  input  logic                    ack_interface2user,
  output logic [ADDR_BITS:0]      rx_level,
  output logic [ADDR_BITS:0]      tx_level,
  output logic [CNT_BITS-1:0]     rx_words,
  output logic [CNT_BITS-1:0]     tx_words
);

  localparam logic [ADDR_BITS:0] FULL_LVL = (ADDR_BITS+1)'(FIFO_DEPTH);

  // ---------------- receive FIFO ----------------
  logic [PAYLOAD_BITS-1:0] rx_mem_q [FIFO_DEPTH];
  logic [ADDR_BITS-1:0]    rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
  logic [ADDR_BITS:0]      rx_level_q, rx_level_d;
  logic [CNT_BITS-1:0]     rx_words_q, rx_words_d;
  logic                    rx_push, rx_pop;

  // A pop in the same cycle does not re-open a full FIFO; ack returns the
  // cycle after the registered level drops.
  assign ack_user2interface = !reset && (rx_level_q != FULL_LVL);
  assign rx_valid           = !reset && (rx_level_q != '0);
  assign rx_push            = vld_interface2user & ack_user2interface;
  assign rx_pop             = rx_valid & rx_ready;
  assign rx_data            = rx_mem_q[rx_rd_q];
  assign rx_level           = rx_level_q;
  assign rx_words           = rx_words_q;

  always_comb begin
    rx_wr_d    = rx_wr_q + ADDR_BITS'(rx_push);
    rx_rd_d    = rx_rd_q + ADDR_BITS'(rx_pop);
    rx_level_d = rx_level_q + (ADDR_BITS+1)'(rx_push) - (ADDR_BITS+1)'(rx_pop);
    rx_words_d = rx_words_q + CNT_BITS'(rx_push);
  end

  always_ff @(posedge clk_user or posedge reset) begin
    if (reset) begin
      rx_wr_q    <= '0;
      rx_rd_q    <= '0;
      rx_level_q <= '0;
      rx_words_q <= '0;
    end else begin
      rx_wr_q    <= rx_wr_d;
      rx_rd_q    <= rx_rd_d;
      rx_level_q <= rx_level_d;
      rx_words_q <= rx_words_d;
    end
  end

  // Storage carries no reset: contents are only observable behind rx_valid.
  always_ff @(posedge clk_user) begin
    if (rx_push) rx_mem_q[rx_wr_q] <= dout_leaf_interface2user;
  end

  // ---------------- transmit FIFO ----------------
  logic [PAYLOAD_BITS-1:0] tx_mem_q [FIFO_DEPTH];
  logic [ADDR_BITS-1:0]    tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
  logic [ADDR_BITS:0]      tx_level_q, tx_level_d;
  logic [CNT_BITS-1:0]     tx_words_q, tx_words_d;
  logic                    tx_push, tx_pop;

  // The head slot is never written while occupied (writes go to the tail and
  // are blocked when full), so vld/din stay stable until the interface acks.
  assign tx_ready                = !reset && (tx_level_q != FULL_LVL);
  assign vld_user2interface      = !reset && (tx_level_q != '0);
  assign tx_push                 = tx_valid & tx_ready;
  assign tx_pop                  = vld_user2interface & ack_interface2user;
  assign din_leaf_user2interface = tx_mem_q[tx_rd_q];
  assign tx_level                = tx_level_q;
  assign tx_words                = tx_words_q;

  always_comb begin
    tx_wr_d    = tx_wr_q + ADDR_BITS'(tx_push);
    tx_rd_d    = tx_rd_q + ADDR_BITS'(tx_pop);
    tx_level_d = tx_level_q + (ADDR_BITS+1)'(tx_push) - (ADDR_BITS+1)'(tx_pop);
    tx_words_d = tx_words_q + CNT_BITS'(tx_pop);
  end

  always_ff @(posedge clk_user or posedge reset) begin
    if (reset) begin
      tx_wr_q    <= '0;
      tx_rd_q    <= '0;
      tx_level_q <= '0;
      tx_words_q <= '0;
    end else begin
      tx_wr_q    <= tx_wr_d;
      tx_rd_q    <= tx_rd_d;
      tx_level_q <= tx_level_d;
      tx_words_q <= tx_words_d;
    end
  end

  always_ff @(posedge clk_user) begin
    if (tx_push) tx_mem_q[tx_wr_q] <= tx_data;
  end

endmodule

// File: tb/tb_leaf_user_port.sv
// Directed bench for leaf_user_port (CNT_BITS = 4 so counter wrap is short).
module tb_leaf_user_port;

  logic        clk_user = 1'b0;
  logic        reset;
  logic [31:0] dout_leaf_interface2user;
  logic        vld_interface2user;
  logic        ack_user2interface;
  logic [31:0] rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [31:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [31:0] din_leaf_user2interface;
  logic        vld_user2interface;
  logic        ack_interface2user;
  logic [2:0]  rx_level, tx_level;
  logic [3:0]  rx_words, tx_words;

  leaf_user_port #(.PAYLOAD_BITS(32), .FIFO_DEPTH(4), .ADDR_BITS(2), .CNT_BITS(4)) dut (
    .clk_user                 (clk_user),
    .reset                    (reset),
    .dout_leaf_interface2user (dout_leaf_interface2user),
    .vld_interface2user       (vld_interface2user),
    .ack_user2interface       (ack_user2interface),
    .rx_data                  (rx_data),
    .rx_valid                 (rx_valid),
    .rx_ready                 (rx_ready),
    .tx_data                  (tx_data),
    .tx_valid                 (tx_valid),
    .tx_ready                 (tx_ready),
    .din_leaf_user2interface  (din_leaf_user2interface),
    .vld_user2interface       (vld_user2interface),
    .ack_interface2user       (ack_interface2user),
    .rx_level                 (rx_level),
    .tx_level                 (tx_level),
    .rx_words                 (rx_words),
    .tx_words                 (tx_words)
  );

  // ---------------- clock ----------------
  always #5 clk_user = ~clk_user;

  // ---------------- vector table ----------------
  typedef struct {
    logic        vld;  logic [31:0] din;  logic rdy;
    logic        txv;  logic [31:0] txd;  logic acki;
    logic        e_ack; logic e_rxv; logic [31:0] e_rxd; logic [2:0] e_rxl; logic [3:0] e_rxw;
    logic        e_txr; logic e_vld; logic [31:0] e_din; logic [2:0] e_txl; logic [3:0] e_txw;
  } vec_t;

  vec_t vecs[$];

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  // receive-side row; transmit side idle and empty
  function automatic void rxv(logic vld, logic [31:0] d, logic rdy, logic e_ack, logic e_rxv,
                              logic [31:0] e_rxd, logic [2:0] e_rxl, logic [3:0] e_rxw);
    vec_t v;
    v.vld = vld; v.din = d; v.rdy = rdy; v.txv = 1'b0; v.txd = '0; v.acki = 1'b0;
    v.e_ack = e_ack; v.e_rxv = e_rxv; v.e_rxd = e_rxd; v.e_rxl = e_rxl; v.e_rxw = e_rxw;
    v.e_txr = 1'b1; v.e_vld = 1'b0; v.e_din = '0; v.e_txl = '0; v.e_txw = '0;
    vecs.push_back(v);
  endfunction

  // transmit-side row; receive side idle, empty, 8 words received so far
  function automatic void txv(logic tv, logic [31:0] d, logic acki, logic e_txr, logic e_vld,
                              logic [31:0] e_din, logic [2:0] e_txl, logic [3:0] e_txw);
    vec_t v;
    v.vld = 1'b0; v.din = '0; v.rdy = 1'b0; v.txv = tv; v.txd = d; v.acki = acki;
    v.e_ack = 1'b1; v.e_rxv = 1'b0; v.e_rxd = '0; v.e_rxl = '0; v.e_rxw = 4'd8;
    v.e_txr = e_txr; v.e_vld = e_vld; v.e_din = e_din; v.e_txl = e_txl; v.e_txw = e_txw;
    vecs.push_back(v);
  endfunction

  // ---------------- driver / checker tasks ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    vld_interface2user = 1'b0; dout_leaf_interface2user = '0; rx_ready = 1'b0;
    tx_valid = 1'b0; tx_data = '0; ack_interface2user = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk_user); #1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    // test 1: three back-to-back receive words with kernel ready
    rxv(1, 32'h11, 1, 1, 0, 32'h00, 0, 0);
    rxv(1, 32'h22, 1, 1, 1, 32'h11, 1, 1);
    rxv(1, 32'h33, 1, 1, 1, 32'h22, 1, 2);
    rxv(0, 32'h00, 1, 1, 1, 32'h33, 1, 3);
    rxv(0, 32'h00, 0, 1, 0, 32'h00, 0, 3);
    // test 2: kernel stalled, fill to 4, one pop while full, then drain
    rxv(1, 32'hA0, 0, 1, 0, 32'h00, 0, 3);
    rxv(1, 32'hA1, 0, 1, 1, 32'hA0, 1, 4);
    rxv(1, 32'hA2, 0, 1, 1, 32'hA0, 2, 5);
    rxv(1, 32'hA3, 0, 1, 1, 32'hA0, 3, 6);
    rxv(1, 32'hA4, 0, 0, 1, 32'hA0, 4, 7);
    rxv(1, 32'hA4, 1, 0, 1, 32'hA0, 4, 7);
    rxv(1, 32'hA4, 0, 1, 1, 32'hA1, 3, 7);
    rxv(0, 32'h00, 1, 0, 1, 32'hA1, 4, 8);
    rxv(0, 32'h00, 1, 1, 1, 32'hA2, 3, 8);
    rxv(0, 32'h00, 1, 1, 1, 32'hA3, 2, 8);
    rxv(0, 32'h00, 1, 1, 1, 32'hA4, 1, 8);
    rxv(0, 32'h00, 0, 1, 0, 32'h00, 0, 8);
    // test 3: transmit fill with no ack, pop on full with held push, alternate acks
    txv(1, 32'hB0, 0, 1, 0, 32'h00, 0, 0);
    txv(1, 32'hB1, 0, 1, 1, 32'hB0, 1, 0);
    txv(1, 32'hB2, 0, 1, 1, 32'hB0, 2, 0);
    txv(1, 32'hB3, 0, 1, 1, 32'hB0, 3, 0);
    txv(1, 32'hB4, 0, 0, 1, 32'hB0, 4, 0);
    txv(1, 32'hB4, 1, 0, 1, 32'hB0, 4, 0);
    txv(1, 32'hB4, 0, 1, 1, 32'hB1, 3, 1);
    txv(0, 32'h00, 0, 0, 1, 32'hB1, 4, 1);
    txv(0, 32'h00, 1, 0, 1, 32'hB1, 4, 1);
    txv(0, 32'h00, 0, 1, 1, 32'hB2, 3, 2);
    txv(0, 32'h00, 1, 1, 1, 32'hB2, 3, 2);
    txv(0, 32'h00, 0, 1, 1, 32'hB3, 2, 3);
    txv(0, 32'h00, 1, 1, 1, 32'hB3, 2, 3);
    txv(0, 32'h00, 0, 1, 1, 32'hB4, 1, 4);
    txv(0, 32'h00, 1, 1, 1, 32'hB4, 1, 4);
    txv(0, 32'h00, 0, 1, 0, 32'h00, 0, 5);

    // reset state
    drive_idle();
    reset = 1'b1;
    #2;
    chk("rst ack", 32'(ack_user2interface), 0);
    chk("rst rx_valid", 32'(rx_valid), 0);
    chk("rst tx_ready", 32'(tx_ready), 0);
    chk("rst vld_out", 32'(vld_user2interface), 0);
    chk("rst rx_level", 32'(rx_level), 0);
    chk("rst tx_level", 32'(tx_level), 0);
    chk("rst rx_words", 32'(rx_words), 0);
    chk("rst tx_words", 32'(tx_words), 0);
    next_cycle();
    reset = 1'b0;

    // table-driven part
    foreach (vecs[i]) begin
      vld_interface2user = vecs[i].vld; dout_leaf_interface2user = vecs[i].din;
      rx_ready = vecs[i].rdy; tx_valid = vecs[i].txv; tx_data = vecs[i].txd;
      ack_interface2user = vecs[i].acki;
      @(negedge clk_user);
      chk($sformatf("v%0d ack", i), 32'(ack_user2interface), 32'(vecs[i].e_ack));
      chk($sformatf("v%0d rx_valid", i), 32'(rx_valid), 32'(vecs[i].e_rxv));
      if (vecs[i].e_rxv) chk($sformatf("v%0d rx_data", i), rx_data, vecs[i].e_rxd);
      chk($sformatf("v%0d rx_level", i), 32'(rx_level), 32'(vecs[i].e_rxl));
      chk($sformatf("v%0d rx_words", i), 32'(rx_words), 32'(vecs[i].e_rxw));
      chk($sformatf("v%0d tx_ready", i), 32'(tx_ready), 32'(vecs[i].e_txr));
      chk($sformatf("v%0d vld_out", i), 32'(vld_user2interface), 32'(vecs[i].e_vld));
      if (vecs[i].e_vld) chk($sformatf("v%0d din_out", i), din_leaf_user2interface, vecs[i].e_din);
      chk($sformatf("v%0d tx_level", i), 32'(tx_level), 32'(vecs[i].e_txl));
      chk($sformatf("v%0d tx_words", i), 32'(tx_words), 32'(vecs[i].e_txw));
      next_cycle();
    end

    // async reset mid-cycle with both FIFOs at level 2
    drive_idle();
    vld_interface2user = 1'b1; dout_leaf_interface2user = 32'hD0;
    tx_valid = 1'b1; tx_data = 32'hE0;
    next_cycle();
    dout_leaf_interface2user = 32'hD1; tx_data = 32'hE1;
    next_cycle();
    drive_idle();
    @(negedge clk_user);
    chk("pre-rst rx_level", 32'(rx_level), 2);
    chk("pre-rst tx_level", 32'(tx_level), 2);
    next_cycle();
    #1;
    vld_interface2user = 1'b1; tx_valid = 1'b1; reset = 1'b1;
    #1;
    chk("midrst ack", 32'(ack_user2interface), 0);
    chk("midrst rx_valid", 32'(rx_valid), 0);
    chk("midrst tx_ready", 32'(tx_ready), 0);
    chk("midrst vld_out", 32'(vld_user2interface), 0);
    chk("midrst rx_level", 32'(rx_level), 0);
    chk("midrst tx_level", 32'(tx_level), 0);
    next_cycle();
    drive_idle();
    reset = 1'b0;
    @(negedge clk_user);
    chk("postrst rx_level", 32'(rx_level), 0);
    chk("postrst tx_level", 32'(tx_level), 0);
    chk("postrst rx_words", 32'(rx_words), 0);
    chk("postrst tx_words", 32'(tx_words), 0);
    chk("postrst rx_valid", 32'(rx_valid), 0);
    chk("postrst vld_out", 32'(vld_user2interface), 0);
    chk("postrst ack", 32'(ack_user2interface), 1);
    chk("postrst tx_ready", 32'(tx_ready), 1);

    // 17 receive words with kernel always ready: counter wraps to 1, order kept
    begin
      int popped = 0;
      next_cycle();
      for (int k = 0; k < 21; k++) begin
        rx_ready = 1'b1;
        if (k < 17) begin
          vld_interface2user = 1'b1;
          dout_leaf_interface2user = 32'hC0 + 32'(k);
          exp_q.push_back(32'hC0 + 32'(k));
        end else begin
          vld_interface2user = 1'b0;
        end
        @(negedge clk_user);
        if (k < 17) chk($sformatf("wrap ack k%0d", k), 32'(ack_user2interface), 1);
        if (rx_valid) begin
          if (exp_q.size() == 0) chk("wrap extra word", rx_data, 32'hFFFF_FFFF);
          else chk($sformatf("wrap data %0d", popped), rx_data, exp_q.pop_front());
          popped++;
        end
        next_cycle();
      end
      drive_idle();
      chk("wrap popped", 32'(popped), 17);
      chk("wrap queue left", 32'(exp_q.size()), 0);
      chk("wrap rx_words", 32'(rx_words), 1);
      chk("wrap rx_level", 32'(rx_level), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // overall time bound
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded its time budget");
    $fatal(1, "timeout");
  end

endmodule
